dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder for the pipelined MIPS core. It is the memory side of the M-stage load/store port: it accepts one word request at a time from the pipeline and executes it after a parameterised number of wait cycles. It returns a one-cycle acknowledge with read data or an error flag. The pipeline's stall logic holds the M stage while the responder is busy, which lets the core run against slow memory instead of a zero-latency array.

## Interface
Parameters:
- ADDR_BITS, 10, word-address width; capacity 2^ADDR_BITS words
- LATENCY, 2, wait cycles between acceptance and completion; legal range 0..15

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- Req  in  1  request valid; held high by the initiator until Ack
- Wr  in  1  1 = store, 0 = load; sampled at acceptance
- Addr  in  32  byte address; bits [1:0] ignored
- WData  in  32  store data; sampled at acceptance
- BE  in  4  byte enables for stores; BE[i] writes byte i (bits 8i+7:8i)
- Busy  out  1  request accepted and not yet acknowledged
- Ack  out  1  one-cycle completion pulse
- RData  out  32  load data; valid while Ack=1, otherwise holds its last value
- Err  out  1  address out of range; valid while Ack=1

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE → WAIT when Req=1. Transition captures Wr, Addr[ADDR_BITS+1:2], WData, BE and a range flag; loads counter with LATENCY-1. If LATENCY=0, the FSM goes directly IDLE → DONE.
- WAIT: counter decrements each cycle. When counter=0, the FSM goes → DONE.
- DONE: Ack=1 for exactly one cycle, then unconditional → IDLE. Req is never accepted in DONE.
- Commit occurs on the edge entering DONE:
  - Store: bytes with BE[i]=1 are written; other bytes are unchanged.
  - Load: RData is registered from the array.
- Range check: Addr[31:ADDR_BITS+2] must be 0. If it is nonzero:
  - stores are suppressed;
  - loads return RData=0;
  - Err=1 with Ack.
- A store with BE=0 completes normally and writes nothing.
- Busy=1 in WAIT and DONE, and 0 in IDLE.
- Req inputs are ignored outside IDLE; changing Req, Wr, Addr, WData or BE mid-transaction has no effect.

## Timing
- Reset (Reset=0 at a rising edge):
  - FSM → IDLE, counter=0.
  - Busy=0, Ack=0, Err=0, RData=0.
  - All memory words are cleared to 0 in that same cycle.
- Reset mid-transaction aborts the transaction: no Ack, and the store is not committed.
- Acceptance: Req=1 sampled in IDLE at edge t. Busy=1 from t. Ack=1 during cycle t+LATENCY+1 (counting edges after t; LATENCY=0 gives Ack one cycle after acceptance).
- Throughput: one request per LATENCY+2 cycles. This includes the mandatory IDLE cycle after DONE.
- Read-after-write to the same word in back-to-back transactions returns the new data.
- Outputs are registered; there is no combinational path from Req to any output.

## Configuration
- DM_WRITE_LOG_EN:
  - Defined: on every committed store, a simulation-only $display prints time, byte address (word index << 2) and the merged 32-bit word as "@addr: *addr <= data". Suppressed stores (Err) print nothing.
  - Undefined: no display statements are compiled; behaviour is otherwise identical.

## Structure
- Shared header (alongside signal_def.v) holds:
  - state encodings DM_IDLE=2'd0, DM_WAIT=2'd1, DM_DONE=2'd2;
  - the counter width constant.
- Sub-module dm_array holds the storage:
  - 2^ADDR_BITS × 32 array;
  - synchronous byte-enabled write;
  - registered read;
  - synchronous clear.
- dm_responder owns the FSM, counter, capture registers and range check.

## Test plan
- Reset, then load Addr=0x0 with LATENCY=2 → Busy rises at acceptance; Ack on the third cycle after acceptance; RData=0; Err=0.
- Store Addr=0x10, WData=0xDEADBEEF, BE=4'b1111, then load 0x10 → second Ack carries RData=0xDEADBEEF.
- Store Addr=0x10, WData=0x00000055, BE=4'b0001 over 0xDEADBEEF, then load → RData=0xDEADBE55.
- Load Addr=0x0000_2000 (out of range, ADDR_BITS=10) → Ack with Err=1 and RData=0. A store to the same address leaves memory unchanged, verified by a loop reading all words.
- Assert Reset=0 during WAIT of a store to 0x20 → no Ack; Busy=0 next cycle; later load 0x20 returns 0.
- LATENCY=0 build: back-to-back held Req → Ack every second cycle. Req held during DONE is not double-accepted (exactly one Ack per request).

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings and
// the wait-counter width.
package dm_responder_pkg;

  localparam int CNT_BITS = 4;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_DONE = 2'd2
  } dm_state_t;

endpackage

// File: rtl/dm_responder_array.sv
// Word storage for dm_responder: byte-enabled synchronous write, registered read, one-cycle clear.
// Defining DM_WRITE_LOG_EN prints every committed store as "@addr: *addr <= data".
module dm_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 rd_zero,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           be,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];
  logic [31:0] merged;

  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Clear wins over any access issued in the same cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (wr_en) mem[addr] <= merged;
      if (rd_en) rdata <= rd_zero ? 32'h0 : mem[addr];
    end
  end

`ifdef DM_WRITE_LOG_EN
  always @(posedge clk) begin
    if (!clear && wr_en)
      $display("%0t @%h: *%h <= %h", $time, {addr, 2'b00}, {addr, 2'b00}, merged);
  end
`else
  // No store logging in the default build.
`endif

endmodule

// File: rtl/dm_responder.sv
// M-stage data-memory responder: accepts one word request, waits LATENCY cycles, then acks.
// Optional store logging in dm_array is enabled by defining DM_WRITE_LOG_EN.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [3:0]  BE,
  output logic        Busy,
  output logic        Ack,
  output logic [31:0] RData,
  output logic        Err
);

  localparam logic [CNT_BITS-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_BITS'(LATENCY - 1);

  dm_state_t state, state_nxt;
  logic [CNT_BITS-1:0]  cnt;
  logic                 cap_wr, cap_oor;
  logic [ADDR_BITS-1:0] cap_idx;
  logic [31:0]          cap_wdata;
  logic [3:0]           cap_be;

  logic                 in_oor, accept, commit;
  logic                 op_wr, op_oor;
  logic [ADDR_BITS-1:0] op_idx;
  logic [31:0]          op_wdata;
  logic [3:0]           op_be;
  logic                 arr_clear, arr_wr, arr_rd;

  assign in_oor = |Addr[31:ADDR_BITS+2];
  assign accept = (state == DM_IDLE) && Req;

  // With LATENCY=0 the commit happens on the accepting edge, before capture registers load.
  assign op_wr    = (state == DM_IDLE) ? Wr                    : cap_wr;
  assign op_oor   = (state == DM_IDLE) ? in_oor                : cap_oor;
  assign op_idx   = (state == DM_IDLE) ? Addr[ADDR_BITS+1:2]   : cap_idx;
  assign op_wdata = (state == DM_IDLE) ? WData                 : cap_wdata;
  assign op_be    = (state == DM_IDLE) ? BE                    : cap_be;

  always_comb begin
    state_nxt = state;
    case (state)
      DM_IDLE: if (Req) state_nxt = (LATENCY == 0) ? DM_DONE : DM_WAIT;
      DM_WAIT: if (cnt == '0) state_nxt = DM_DONE;
      DM_DONE: state_nxt = DM_IDLE;
      default: state_nxt = DM_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= DM_IDLE;
      cnt       <= '0;
      cap_wr    <= 1'b0;
      cap_oor   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_wr    <= Wr;
        cap_oor   <= in_oor;
        cap_idx   <= Addr[ADDR_BITS+1:2];
        cap_wdata <= WData;
        cap_be    <= BE;
        cnt       <= CNT_LOAD;
      end else if (state == DM_WAIT && cnt != '0) begin
        cnt <= cnt - CNT_BITS'(1);
      end
    end
  end

  assign commit    = (state_nxt == DM_DONE) && (state != DM_DONE);
  assign arr_clear = !Reset;
  assign arr_wr    = commit && op_wr && !op_oor;
  assign arr_rd    = commit && !op_wr;

  dm_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk     (Clk),
    .clear   (arr_clear),
    .wr_en   (arr_wr),
    .rd_en   (arr_rd),
    .rd_zero (op_oor),
    .addr    (op_idx),
    .wdata   (op_wdata),
    .be      (op_be),
    .rdata   (RData)
  );

  assign Busy = (state != DM_IDLE);
  assign Ack  = (state == DM_DONE);
  assign Err  = Ack && cap_oor;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a LATENCY=2 and a LATENCY=0 instance checked
// every cycle against a transaction-level memory model, plus literal scenario checks.
module tb_dm_responder;

  localparam int AB = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic        wr [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be [2];
  logic        busy [2];
  logic        ack [2];
  logic        err [2];
  logic [31:0] rdata [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_BITS(AB), .LATENCY(2)) dut (
    .Clk(clk), .Reset(rst_n), .Req(req[0]), .Wr(wr[0]), .Addr(addr[0]),
    .WData(wdata[0]), .BE(be[0]), .Busy(busy[0]), .Ack(ack[0]),
    .RData(rdata[0]), .Err(err[0])
  );

  dm_responder #(.ADDR_BITS(AB), .LATENCY(0)) dut0 (
    .Clk(clk), .Reset(rst_n), .Req(req[1]), .Wr(wr[1]), .Addr(addr[1]),
    .WData(wdata[1]), .BE(be[1]), .Busy(busy[1]), .Ack(ack[1]),
    .RData(rdata[1]), .Err(err[1])
  );

  // Transaction-level model: each accepted request completes LATENCY edges after acceptance.
  logic [31:0] mmem [2][1 << AB];
  int          ec = 0;
  bit          pend [2] = '{0, 0};
  int          done_at [2];
  bit          m_wr [2];
  logic [31:0] m_addr [2], m_wd [2];
  logic [3:0]  m_be [2];
  bit          e_busy [2] = '{0, 0};
  bit          e_ack [2] = '{0, 0};
  bit          e_err [2] = '{0, 0};
  logic [31:0] e_rd [2] = '{32'h0, 32'h0};

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  always @(posedge clk) begin
    ec++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        pend[d] = 0; e_busy[d] = 0; e_ack[d] = 0; e_err[d] = 0; e_rd[d] = 32'h0;
        for (int i = 0; i < (1 << AB); i++) mmem[d][i] = 32'h0;
      end else begin
        if (e_ack[d]) begin
          e_ack[d] = 0; e_err[d] = 0; e_busy[d] = 0;
        end else if (!pend[d] && req[d]) begin
          pend[d] = 1; e_busy[d] = 1; done_at[d] = ec + latOf(d);
          m_wr[d] = wr[d]; m_addr[d] = addr[d]; m_wd[d] = wdata[d]; m_be[d] = be[d];
        end
        if (pend[d] && ec == done_at[d]) begin
          bit oor;
          pend[d] = 0; e_ack[d] = 1;
          oor = (m_addr[d][31:AB+2] != 0);
          e_err[d] = oor;
          if (m_wr[d]) begin
            if (!oor)
              for (int b = 0; b < 4; b++)
                if (m_be[d][b]) mmem[d][m_addr[d][AB+1:2]][8*b +: 8] = m_wd[d][8*b +: 8];
          end else begin
            e_rd[d] = oor ? 32'h0 : mmem[d][m_addr[d][AB+1:2]];
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ec > 0) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(e_busy[d]));
        checkOutput($sformatf("ack[%0d]", d), 32'(ack[d]), 32'(e_ack[d]));
        checkOutput($sformatf("rdata[%0d]", d), rdata[d], e_rd[d]);
        if (e_ack[d]) checkOutput($sformatf("err[%0d]", d), 32'(err[d]), 32'(e_err[d]));
      end
    end
  end

  // Drives one request from the current negedge and waits (bounded) for its Ack.
  task automatic applyStimulus(input int d, input bit w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] b,
                               input bit drop, input bit scramble,
                               output logic [31:0] rd, output bit er, output int cyc);
    bit got = 0;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    cyc = 0; rd = 32'h0; er = 0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (ack[d]) begin
        got = 1; rd = rdata[d]; er = err[d];
      end else if (scramble) begin
        wr[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
      end
    end
    if (!got) checkOutput("ack_timeout", 32'(got), 32'h1);
    if (drop) req[d] = 1'b0;
  endtask

  task automatic randomPhase(input int d, input int n);
    logic [31:0] rd, a;
    bit er;
    int cyc;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_1000;
      else a = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      applyStimulus(d, 1'($urandom), a, $urandom, 4'($urandom), 1'b1, 1'b1, rd, er, cyc);
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit er;
    int cyc, bad;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; be[d] = 4'h0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy[0]), 32'h0);
    checkOutput("reset_ack", 32'(ack[0]), 32'h0);
    checkOutput("reset_rdata", rdata[0], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, rd, er, cyc);
    checkOutput("lat2_ack_cycles", cyc, 3);
    checkOutput("load0_rdata", rd, 32'h0);
    checkOutput("load0_err", 32'(er), 32'h0);

    @(negedge clk);
    applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, rd, er, cyc);
    applyStimulus(0, 0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, rd, er, cyc);
    checkOutput("raw_full_word", rd, 32'hDEADBEEF);
    applyStimulus(0, 1, 32'h10, 32'h00000055, 4'b0001, 1'b1, 1'b0, rd, er, cyc);
    applyStimulus(0, 0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0, rd, er, cyc);
    checkOutput("byte_merge", rd, 32'hDEADBE55);

    applyStimulus(0, 0, 32'h0000_2000, 32'h0, 4'h0, 1'b1, 1'b0, rd, er, cyc);
    checkOutput("oor_load_err", 32'(er), 32'h1);
    checkOutput("oor_load_rdata", rd, 32'h0);
    applyStimulus(0, 1, 32'h0000_2000, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, rd, er, cyc);
    checkOutput("oor_store_err", 32'(er), 32'h1);
    bad = 0;
    for (int i = 0; i < (1 << AB); i++) begin
      applyStimulus(0, 0, 32'(i) << 2, 32'h0, 4'h0, 1'b1, 1'b0, rd, er, cyc);
      if (rd !== ((i == 4) ? 32'hDEADBE55 : 32'h0)) bad++;
    end
    checkOutput("sweep_bad_words", bad, 0);

    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
    @(negedge clk);
    rst_n = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy[0]), 32'h0);
    checkOutput("abort_ack", 32'(ack[0]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0, rd, er, cyc);
    checkOutput("abort_no_commit", rd, 32'h0);

    randomPhase(0, 150);

    @(negedge clk);
    applyStimulus(1, 1, 32'h40, 32'h12345678, 4'hF, 1'b0, 1'b0, rd, er, cyc);
    checkOutput("lat0_ack_cycles", cyc, 1);
    applyStimulus(1, 0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, rd, er, cyc);
    checkOutput("lat0_b2b_cycles", cyc, 2);
    checkOutput("lat0_raw", rd, 32'h12345678);
    applyStimulus(1, 1, 32'h44, 32'hAAAABBBB, 4'b0011, 1'b0, 1'b0, rd, er, cyc);
    checkOutput("lat0_b2b_store_cycles", cyc, 2);
    applyStimulus(1, 0, 32'h44, 32'h0, 4'h0, 1'b1, 1'b0, rd, er, cyc);
    checkOutput("lat0_b2b_load_cycles", cyc, 2);
    checkOutput("lat0_half_word", rd, 32'h0000BBBB);

    randomPhase(1, 100);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
